uart_tx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_core.sv | 148 ++++++++++++++
 tb/tb_uart_tx_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants and the frame FSM encoding.
package uart_pkg;

    localparam int unsigned UART_PARITY_NONE = 0;
    localparam int unsigned UART_PARITY_ODD  = 1;
    localparam int unsigned UART_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: pulses bit_done in the last cycle of each CLKS_PER_BIT period.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic bit_done
);

    localparam int unsigned    CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] count;

    // Period counter: cleared on restart, wraps at the end of each bit while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign bit_done = en && (count == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter with a one-entry holding register for back-to-back frames.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be 5..8");
    end
    if (PARITY > UART_PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != UART_PARITY_NONE);
    localparam logic             PAR_ODD   = (PARITY == UART_PARITY_ODD);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] hold_data, shifter;
    logic                 hold_full, hold_full_next;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 parity_acc;
    logic                 bit_done, accept, load, stop_end, line_next;
    logic                 baud_restart, baud_en;
    logic                 unused_data;

    // Upper tx_data bits are deliberately not transmitted for narrow frames.
    assign unused_data = ^tx_data;

    assign accept         = tx_valid && tx_ready;
    assign stop_end       = (state == ST_STOP) && bit_done && (stop_cnt == LAST_STOP);
    assign load           = hold_full && ((state == ST_IDLE) || stop_end);
    assign hold_full_next = accept ? 1'b1 : (load ? 1'b0 : hold_full);

    assign baud_en      = (state != ST_IDLE);
    assign baud_restart = (state == ST_IDLE) || (state_next != state);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .restart (baud_restart),
        .en      (baud_en),
        .bit_done(bit_done)
    );

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the line level of the bit that starts at the coming edge
    always_comb begin
        state_next = state;
        line_next  = uart_tx;
        case (state)
            ST_IDLE:   if (hold_full) state_next = ST_START;
            ST_START:  if (bit_done) state_next = ST_DATA;
            ST_DATA:   if (bit_done && bit_idx == LAST_IDX)
                           state_next = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_next = ST_STOP;
            ST_STOP:   if (stop_end) state_next = hold_full ? ST_START : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Line is registered, so the next bit is chosen from pre-shift data:
        // shifter[0] on DATA entry, shifter[1] on each later data bit.
        case (state_next)
            ST_START:  line_next = 1'b0;
            ST_DATA: begin
                if (state == ST_START) begin
                    line_next = shifter[0];
                end else if (bit_done) begin
                    line_next = shifter[1];
                end
            end
            ST_PARITY: if (state == ST_DATA) line_next = parity_acc ^ shifter[0] ^ PAR_ODD;
            default:   line_next = 1'b1;
        endcase
    end

    // Holding register, shifter, bit index, stop counter and parity accumulator
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shifter    <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            parity_acc <= 1'b0;
        end else begin
            hold_full <= hold_full_next;
            if (accept) begin
                hold_data <= tx_data[DATA_BITS-1:0];
            end
            if (load) begin
                shifter    <= hold_data;
                bit_idx    <= '0;
                parity_acc <= 1'b0;
            end else if (state == ST_DATA && bit_done) begin
                shifter    <= shifter >> 1;
                bit_idx    <= bit_idx + 1'b1;
                parity_acc <= parity_acc ^ shifter[0];
            end
            if (state != ST_STOP || stop_end) begin
                stop_cnt <= 1'b0;
            end else if (bit_done) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            uart_tx  <= line_next;
            tx_ready <= !hold_full_next;
            tx_busy  <= (state_next != ST_IDLE) || hold_full_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: 8N1, 8E2, 8O1 and 7N1 instances at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx_core;

    typedef logic [11:0] frame_t;
    typedef struct { int inst; frame_t frame; } exp_t;
    typedef struct { int inst; logic [7:0] data; frame_t frame; int nbits; } vec_t;

    localparam int NI  = 4;
    localparam int CPB = 4;
    localparam int DB[NI] = '{8, 8, 8, 7};
    localparam int PM[NI] = '{0, 2, 1, 0};
    localparam int SB[NI] = '{1, 2, 1, 1};
    localparam int NB[NI] = '{10, 12, 11, 9};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid [NI];
    logic [7:0] data  [NI];
    logic       ready [NI];
    logic       line  [NI];
    logic       busy  [NI];

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   cyc = 0;
    int   rst_gen = 0;
    int   last_start [NI];
    int   prev_start [NI];
    int   frames_seen[NI];
    bit   bp_on = 1'b0;
    int   ready_rises = 0;

    uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_8n1 (
        .sys_clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
        .tx_ready(ready[0]), .uart_tx(line[0]), .tx_busy(busy[0]));
    uart_tx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_8e2 (
        .sys_clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
        .tx_ready(ready[1]), .uart_tx(line[1]), .tx_busy(busy[1]));
    uart_tx_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_8o1 (
        .sys_clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2]),
        .tx_ready(ready[2]), .uart_tx(line[2]), .tx_busy(busy[2]));
    uart_tx_core #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_7n1 (
        .sys_clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3]),
        .tx_ready(ready[3]), .uart_tx(line[3]), .tx_busy(busy[3]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge rst_n) rst_gen = rst_gen + 1;

    always @(posedge ready[0]) if (bp_on) ready_rises = ready_rises + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference frame: start, DATA_BITS data LSB first, optional parity, stop bits.
    function automatic frame_t make_frame(input int g, input logic [7:0] d);
        frame_t f;
        int p;
        int ones;
        f = '0;
        p = 1;
        ones = 0;
        for (int i = 0; i < DB[g]; i++) begin
            f[p] = d[i];
            ones += int'(d[i]);
            p++;
        end
        if (PM[g] != 0) begin
            f[p] = (PM[g] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            p++;
        end
        for (int i = 0; i < SB[g]; i++) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    // Line monitors: decode each frame mid-bit and compare with the scoreboard.
    for (genvar g = 0; g < NI; g++) begin : g_mon
        initial begin
            logic   prev;
            frame_t cap;
            int     gen;
            bit     ok;
            exp_t   e;
            prev = 1'b1;
            frames_seen[g] = 0;
            last_start[g] = 0;
            prev_start[g] = 0;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && prev === 1'b1 && line[g] === 1'b0) begin
                    prev_start[g] = last_start[g];
                    last_start[g] = cyc;
                    cap = '0;
                    gen = rst_gen;
                    ok = 1'b1;
                    for (int b = 0; b < NB[g]; b++) begin
                        repeat ((b == 0) ? 2 : CPB) @(negedge clk);
                        if (rst_gen != gen) begin
                            ok = 1'b0;
                            break;
                        end
                        cap[b] = line[g];
                    end
                    if (ok) begin
                        frames_seen[g]++;
                        if (sb.size() == 0) begin
                            fail_now($sformatf("mon%0d_unexpected_frame got 0x%0h", g, cap));
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("mon%0d_inst", g), g, e.inst);
                            chk($sformatf("mon%0d_frame", g), 32'(cap), 32'(e.frame));
                        end
                    end
                end
                prev = line[g];
            end
        end
    end

    task automatic send(input int g, input logic [7:0] d);
        int n;
        n = 0;
        valid[g] = 1'b1;
        data[g] = d;
        while (ready[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (ready[g] !== 1'b1) begin
            fail_now($sformatf("send%0d_ready_timeout", g));
            valid[g] = 1'b0;
            return;
        end
        sb.push_back('{g, make_frame(g, d)});
        @(posedge clk);
        #1;
        valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int bound, input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && busy[g] === 1'b0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!(sb.size() == 0 && busy[g] === 1'b0)) fail_now({name, "_idle_timeout"});
    endtask

    // Exact cycle-level check of one frame from an idle transmitter.
    task automatic apply_vector(input vec_t v, input int idx);
        int g;
        int len;
        g = v.inst;
        len = v.nbits * CPB;
        @(negedge clk);
        chk($sformatf("v%0d_ready_pre", idx), ready[g], 1);
        valid[g] = 1'b1;
        data[g] = v.data;
        sb.push_back('{g, v.frame});
        @(posedge clk);
        #1;
        valid[g] = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_accept_state", idx), {ready[g], busy[g], line[g]}, 3'b011);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            chk($sformatf("v%0d_line_c%0d", idx, j), line[g], v.frame[j / CPB]);
            if (j == 0) chk($sformatf("v%0d_ready_back", idx), ready[g], 1);
            if (j == len - 1) chk($sformatf("v%0d_busy_last", idx), busy[g], 1);
        end
        @(negedge clk);
        chk($sformatf("v%0d_busy_drop", idx), {busy[g], line[g]}, 2'b01);
    endtask

    initial begin
        vec_t       vt[8];
        logic [7:0] bp[3];
        int         k0;
        int         f0;
        int         acc;
        logic       r;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i] = 8'h00;
        end

        vt[0] = '{0, 8'hA5, frame_t'({1'b1, 8'hA5, 1'b0}), 10};
        vt[1] = '{0, 8'h00, frame_t'({1'b1, 8'h00, 1'b0}), 10};
        vt[2] = '{1, 8'h07, frame_t'({2'b11, 1'b1, 8'h07, 1'b0}), 12};
        vt[3] = '{1, 8'h55, frame_t'({2'b11, 1'b0, 8'h55, 1'b0}), 12};
        vt[4] = '{2, 8'h07, frame_t'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
        vt[5] = '{2, 8'h55, frame_t'({1'b1, 1'b1, 8'h55, 1'b0}), 11};
        vt[6] = '{3, 8'hC1, frame_t'({1'b1, 7'h41, 1'b0}), 9};
        vt[7] = '{0, 8'hFF, frame_t'({1'b1, 8'hFF, 1'b0}), 10};
        bp[0] = 8'h11;
        bp[1] = 8'h2E;
        bp[2] = 8'hF0;

        // Reset state, then 50 idle cycles after release
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("rst_in%0d", i), {line[i], ready[i], busy[i]}, 3'b110);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                chk($sformatf("idle%0d_c%0d", i, c), {line[i], ready[i], busy[i]}, 3'b110);
        end

        // Table-driven single frames
        foreach (vt[i]) begin
            apply_vector(vt[i], i);
            repeat (2) @(negedge clk);
        end

        // 7N1 back-to-back; bit 7 of tx_data set but never transmitted
        f0 = frames_seen[3];
        @(negedge clk);
        send(3, 8'hC1);
        send(3, 8'hC2);
        wait_idle(3, 300, "b2b");
        chk("b2b_frames", frames_seen[3] - f0, 2);
        chk("b2b_start_spacing", last_start[3] - prev_start[3], 36);

        // Reset during DATA bit 3 of 0x00 with a second byte held
        repeat (3) @(negedge clk);
        send(0, 8'h00);
        k0 = cyc;
        send(0, 8'h3C);
        while (cyc < k0 + 18) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("mid_pre_line", {line[0], ready[0], busy[0]}, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("mid_async", {line[0], ready[0], busy[0]}, 3'b110);
        sb.delete();
        f0 = frames_seen[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk($sformatf("mid_after_c%0d", c), {line[0], ready[0], busy[0]}, 3'b110);
        end
        chk("mid_no_frames", frames_seen[0] - f0, 0);

        // Backpressure: tx_valid held high across three bytes
        acc = 0;
        ready_rises = 0;
        bp_on = 1'b1;
        f0 = frames_seen[0];
        @(negedge clk);
        valid[0] = 1'b1;
        data[0] = bp[0];
        for (int c = 0; c < 600 && !(acc == 3 && busy[0] === 1'b0 && sb.size() == 0); c++) begin
            r = ready[0];
            @(posedge clk);
            if (r === 1'b1 && valid[0]) begin
                sb.push_back('{0, make_frame(0, bp[acc])});
                acc++;
                #1;
                if (acc < 3) data[0] = bp[acc];
                else valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        bp_on = 1'b0;
        valid[0] = 1'b0;
        chk("bp_accepts", acc, 3);
        chk("bp_ready_rises", ready_rises, 3);
        chk("bp_frames", frames_seen[0] - f0, 3);
        chk("bp_busy_end", busy[0], 0);

        repeat (5) @(negedge clk);
        chk("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
